uart8250_bridge: RTL and testbench
==================================

# uart8250_bridge

Parametrised 8250/16450-compatible serial-port emulation bridging the x86 CPU I/O space to the RISC-V service core. Two byte FIFOs: RX (RISC-V → CPU, e.g. mouse packets) and TX (CPU → RISC-V). Provides the full 8-register UART map, an IIR-driven interrupt with OUT2 gating, overrun reporting, and a configurable device-ID burst on RTS rising edge. Sits on the CPU toggle-handshake I/O bus beside the other port peripherals. Instantiated once per COM port.

## Interface
- BASE_PORT, 12'h3F8, base I/O address; bits [2:0] must be 0
- DEPTH_LOG2, 4, log2 of each FIFO depth; depth D = 2^DEPTH_LOG2
- ID_BYTE, 8'h4D, byte loaded into RX on RTS rising edge
- ID_COUNT, 6, number of ID_BYTE copies; 0 disables; ≤ D
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- r_addr  in  10  RISC-V word address; [0] selects register
- r_din  in  32  RISC-V write data
- r_dout  out  32  RISC-V read data
- r_lane  in  4  byte enables; write honoured only if r_lane[0]
- r_wr  in  1  1 = write, 0 = read
- r_valid  in  1  RISC-V request
- r_ready  out  1  RISC-V acknowledge
- port  in  12  CPU I/O address
- din  in  8  CPU write data
- dout  out  8  CPU read data (combinational)
- cpu_iordin / cpu_iowrin  in  1  read/write request toggles
- cpu_iordout / cpu_iowrout  out  1  acknowledge toggles
- irq  out  1  interrupt request, active-high level

## Operation
- Select: sel = (port[11:3] == BASE_PORT[11:3]). iord = cpu_iordin ^ cpu_iordout; iowr likewise. Every clk: cpu_iordout <= cpu_iordin, cpu_iowrout <= cpu_iowrin. Side effects only when sel & iord/iowr.
- Offset 0: DLAB=0 read pops RX (RBR), write pushes TX (THR); DLAB=1 DLL (reset 0x0C).
- Offset 1: DLAB=0 IER[1:0] (bit0 RDA, bit1 THRE; upper bits read 0); DLAB=1 DLM (reset 0).
- Offset 2 IIR (read-only): 0x04 if IER0 & RX non-empty; else 0x02 if IER1 & thre_flag; else 0x01. Reading 0x02 clears thre_flag.
- Offset 3 LCR (bit7 = DLAB). Offset 7 SCR, plain R/W.
- Offset 4 MCR[4:0]. A write where MCR[1] goes 0→1 flushes RX and loads ID_COUNT × ID_BYTE (rp=0, count=ID_COUNT); OE cleared.
- Offset 5 LSR: bit0 DR = RX non-empty; bit1 OE (sticky; set on RISC-V push to full RX; cleared by LSR read); bit5 THRE = TX not full; bit6 TEMT = TX empty; other bits 0.
- Offset 6 MSR: constant 0xB0.
- thre_flag: set when TX becomes empty (pop of last byte) or IER1 written 0→1 while TX empty; cleared by THR write or IIR read returning 0x02.
- irq = MCR[3] & (IIR != 0x01), registered.
- FIFOs: D entries each; explicit count (DEPTH_LOG2+1 bits); pointers wrap modulo D. Pop empty RX → RBR returns last-read byte, no state change. Push full TX → byte dropped.
- RISC-V: request accepted when r_valid & ~r_ready; r_ready pulses 1 cycle after. Addr 0 write: push r_din[7:0] to RX. Addr 0 read: r_dout = {23'b0, valid, byte}, pops TX if non-empty, else 0. Addr 1 read: {15'b0, OE, tx_count[7:0], rx_count[7:0]}. Addr 1 write: bit0 flushes TX.

## Timing
- Reset: all FIFOs empty, pointers 0; r_ready 0, r_dout 0, irq 0, cpu_iordout/iowrout 0; IER/LCR/MCR/SCR/DLM 0, DLL 0x0C, OE 0, thre_flag 1.
- CPU access completes in 1 clk: action and acknowledge toggle on the same edge. dout reflects current state during the request cycle, before the pop.
- RISC-V latency: r_ready and r_dout valid 1 cycle after r_valid; r_valid held high never repeats the access until r_ready returns to 0.
- Simultaneous RX push (RISC-V) and RX pop (CPU): both occur, count unchanged; push to full with concurrent pop succeeds, no OE.
- MCR-RTS load and RISC-V RX push in the same cycle: load wins, push dropped, r_ready still pulses.
- Simultaneous TX push and TX pop: both occur; thre_flag not set.
- irq reflects state changes one cycle after the causing edge.
- Reset mid-transfer: immediate asynchronous clear; pending toggles resynchronise on the first clock after release.

## Test plan
- Reset, read offset 5 → 0x60; offset 2 → 0x01; DLAB=1 read offset 0 → 0x0C.
- Write MCR 0x0B then 0x0B→RTS rising from 0x00: six reads of offset 0 → 0x4D each, LSR bit0 then 0.
- IER=0x01, MCR=0x08, RISC-V push 0x12 → irq=1 next cycle, IIR=0x04; CPU reads 0x12 → irq=0.
- RISC-V pushes D+1 bytes without CPU reads → rx_count=D, LSR=0x63 (OE set); second LSR read → 0x61.
- CPU writes 0x41,0x42 to THR; RISC-V reads addr 0 twice → 0x141, 0x142, third → 0x000; with IER=0x02 and OUT2, irq rises after last pop; IIR read 0x02 clears it.
- Same-cycle RX push and CPU pop at count=D → count stays D, no OE.

Source files
------------

// File: rtl/uart8250_bridge.sv
// 8250/16450 register-compatible serial port between the CPU toggle-handshake I/O bus
// and the RISC-V service core. RX carries RISC-V -> CPU bytes, TX carries CPU -> RISC-V bytes.
module uart8250_bridge #(
    parameter logic [11:0] BASE_PORT  = 12'h3F8,
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  ID_BYTE    = 8'h4D,
    parameter int          ID_COUNT   = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  r_addr,
    input  logic [31:0] r_din,
    output logic [31:0] r_dout,
    input  logic [3:0]  r_lane,
    input  logic        r_wr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [11:0] port,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        cpu_iordin,
    input  logic        cpu_iowrin,
    output logic        cpu_iordout,
    output logic        cpu_iowrout,
    output logic        irq
);
    localparam int D  = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         L_FULL  = CW'(D);
    localparam logic [CW-1:0]         L_CONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] L_PONE  = DEPTH_LOG2'(1);

    logic [7:0]            r_rx_mem [D];
    logic [7:0]            r_tx_mem [D];
    logic [DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [CW-1:0]         r_rx_cnt, r_tx_cnt;
    logic [7:0]            r_rbr_last, r_lcr, r_scr, r_dll, r_dlm;
    logic [1:0]            r_ier;
    logic [4:0]            r_mcr;
    logic                  r_oe, r_thre;

    logic       w_sel, w_iord, w_iowr, w_dlab;
    logic [2:0] w_off;
    logic       w_rd_rbr, w_rd_iir, w_rd_lsr, w_wr_thr, w_wr_ier, w_wr_mcr, w_rts_load;
    logic       w_acc, w_rv_wr, w_rv_push, w_rv_flush, w_rv_rd_data;
    logic       w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_oe_set;
    logic       w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_thre_set, w_thre_clr;
    logic [7:0] w_iir, w_lsr;
    logic       w_unused;

    assign w_unused = ^{r_addr[9:1], r_din[31:8], r_lane[3:1]};

    // CPU side: a request is pending while the input toggle differs from its acknowledge.
    assign w_sel      = (port[11:3] == BASE_PORT[11:3]);
    assign w_iord     = w_sel & (cpu_iordin ^ cpu_iordout);
    assign w_iowr     = w_sel & (cpu_iowrin ^ cpu_iowrout);
    assign w_off      = port[2:0];
    assign w_dlab     = r_lcr[7];
    assign w_rd_rbr   = w_iord & (w_off == 3'd0) & ~w_dlab;
    assign w_rd_iir   = w_iord & (w_off == 3'd2);
    assign w_rd_lsr   = w_iord & (w_off == 3'd5);
    assign w_wr_thr   = w_iowr & (w_off == 3'd0) & ~w_dlab;
    assign w_wr_ier   = w_iowr & (w_off == 3'd1) & ~w_dlab;
    assign w_wr_mcr   = w_iowr & (w_off == 3'd4);
    assign w_rts_load = w_wr_mcr & din[1] & ~r_mcr[1];

    assign w_acc        = r_valid & ~r_ready;
    assign w_rv_wr      = w_acc & r_wr & r_lane[0];
    assign w_rv_push    = w_rv_wr & ~r_addr[0];
    assign w_rv_flush   = w_rv_wr & r_addr[0] & r_din[0];
    assign w_rv_rd_data = w_acc & ~r_wr & ~r_addr[0];

    // A concurrent CPU pop frees the slot, so a push into a full RX still lands.
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == L_FULL);
    assign w_rx_pop   = w_rd_rbr & ~w_rx_empty;
    assign w_rx_push  = w_rv_push & ~w_rts_load & (~w_rx_full | w_rx_pop);
    assign w_oe_set   = w_rv_push & ~w_rts_load & w_rx_full & ~w_rx_pop;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == L_FULL);
    assign w_tx_pop   = w_rv_rd_data & ~w_tx_empty;
    assign w_tx_push  = w_wr_thr & ~w_tx_full & ~w_rv_flush;
    assign w_thre_set = (w_tx_pop & ~w_tx_push & (r_tx_cnt == L_CONE))
                      | (w_wr_ier & din[1] & ~r_ier[1] & w_tx_empty);
    assign w_thre_clr = w_wr_thr | (w_rd_iir & (w_iir == 8'h02));

    assign w_iir = (r_ier[0] & ~w_rx_empty) ? 8'h04 :
                   (r_ier[1] & r_thre)      ? 8'h02 : 8'h01;
    assign w_lsr = {1'b0, w_tx_empty, ~w_tx_full, 3'b000, r_oe, ~w_rx_empty};

    always_comb begin
        dout = 8'h00;
        if (w_sel) begin
            case (w_off)
                3'd0:    dout = w_dlab ? r_dll : (w_rx_empty ? r_rbr_last : r_rx_mem[r_rx_rp]);
                3'd1:    dout = w_dlab ? r_dlm : {6'b0, r_ier};
                3'd2:    dout = w_iir;
                3'd3:    dout = r_lcr;
                3'd4:    dout = {3'b0, r_mcr};
                3'd5:    dout = w_lsr;
                3'd6:    dout = 8'hB0;
                default: dout = r_scr;
            endcase
        end
    end

    // RTS load overwrites the first ID_COUNT slots; it suppresses any push in that cycle.
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_din[7:0];
        for (int i = 0; i < D; i++) begin
            if (w_rts_load && i < ID_COUNT) r_rx_mem[i] <= ID_BYTE;
        end
        if (w_tx_push) r_tx_mem[r_tx_wp] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_iordout <= 1'b0;
            cpu_iowrout <= 1'b0;
            r_ready     <= 1'b0;
            r_dout      <= 32'h0;
            irq         <= 1'b0;
            r_rx_wp     <= '0;
            r_rx_rp     <= '0;
            r_rx_cnt    <= '0;
            r_tx_wp     <= '0;
            r_tx_rp     <= '0;
            r_tx_cnt    <= '0;
            r_rbr_last  <= 8'h00;
            r_ier       <= 2'b00;
            r_lcr       <= 8'h00;
            r_mcr       <= 5'h00;
            r_scr       <= 8'h00;
            r_dll       <= 8'h0C;
            r_dlm       <= 8'h00;
            r_oe        <= 1'b0;
            r_thre      <= 1'b1;
        end else begin
            cpu_iordout <= cpu_iordin;
            cpu_iowrout <= cpu_iowrin;
            r_ready     <= w_acc;
            irq         <= r_mcr[3] & (w_iir != 8'h01);

            if (w_acc) begin
                if (r_wr)            r_dout <= 32'h0;
                else if (r_addr[0])  r_dout <= {15'b0, r_oe, 8'(r_tx_cnt), 8'(r_rx_cnt)};
                else if (w_tx_empty) r_dout <= 32'h0;
                else                 r_dout <= {23'b0, 1'b1, r_tx_mem[r_tx_rp]};
            end

            if (w_rts_load) begin
                r_rx_rp  <= '0;
                r_rx_wp  <= DEPTH_LOG2'(ID_COUNT);
                r_rx_cnt <= CW'(ID_COUNT);
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + L_PONE;
                if (w_rx_pop) begin
                    r_rx_rp    <= r_rx_rp + L_PONE;
                    r_rbr_last <= r_rx_mem[r_rx_rp];
                end
                if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + L_CONE;
                else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - L_CONE;
            end

            if (w_rv_flush) begin
                r_tx_wp  <= '0;
                r_tx_rp  <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + L_PONE;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + L_PONE;
                if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + L_CONE;
                else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - L_CONE;
            end

            // A set in the same cycle as an LSR read wins so the overrun is not lost.
            if (w_rts_load)    r_oe <= 1'b0;
            else if (w_oe_set) r_oe <= 1'b1;
            else if (w_rd_lsr) r_oe <= 1'b0;

            if (w_thre_set)      r_thre <= 1'b1;
            else if (w_thre_clr) r_thre <= 1'b0;

            if (w_iowr) begin
                case (w_off)
                    3'd0: if (w_dlab) r_dll <= din;
                    3'd1: if (w_dlab) r_dlm <= din; else r_ier <= din[1:0];
                    3'd3: r_lcr <= din;
                    3'd4: r_mcr <= din[4:0];
                    3'd7: r_scr <= din;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart8250_bridge.sv
// Scoreboard bench for uart8250_bridge: a queue-based model predicts every CPU and
// RISC-V read; monitors compare whenever the DUT presents a response.
module tb_uart8250_bridge;
    localparam logic [11:0] BASE = 12'h3F8;
    localparam int          D    = 16;
    localparam int          IDN  = 6;
    localparam logic [7:0]  IDB  = 8'h4D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  r_addr = '0;
    logic [31:0] r_din = '0;
    logic [31:0] r_dout;
    logic [3:0]  r_lane = '0;
    logic        r_wr = 1'b0;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [11:0] port = BASE;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        cpu_iordin = 1'b0;
    logic        cpu_iowrin = 1'b0;
    logic        cpu_iordout, cpu_iowrout, irq;

    always #5 clk = ~clk;

    uart8250_bridge #(.BASE_PORT(BASE), .DEPTH_LOG2(4), .ID_BYTE(IDB), .ID_COUNT(IDN)) dut (
        .clk(clk), .reset_n(reset_n),
        .r_addr(r_addr), .r_din(r_din), .r_dout(r_dout), .r_lane(r_lane),
        .r_wr(r_wr), .r_valid(r_valid), .r_ready(r_ready),
        .port(port), .din(din), .dout(dout),
        .cpu_iordin(cpu_iordin), .cpu_iowrin(cpu_iowrin),
        .cpu_iordout(cpu_iordout), .cpu_iowrout(cpu_iowrout), .irq(irq)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: the UART as two byte queues plus a handful of register values.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [1:0] m_ier;
    logic [7:0] m_lcr, m_scr, m_dll, m_dlm, m_last;
    logic [4:0] m_mcr;
    bit         m_oe, m_thre;

    logic [10:0] cpu_q[$];   // {offset, expected dout}
    logic [32:0] rv_q[$];    // {check?, expected r_dout}
    logic [10:0] cpu_ent;
    logic [32:0] rv_ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        rxq.delete(); txq.delete();
        m_ier = 0; m_lcr = 0; m_scr = 0; m_dll = 8'h0C; m_dlm = 0; m_last = 0;
        m_mcr = 0; m_oe = 0; m_thre = 1;
    endtask

    function automatic logic [7:0] m_iir();
        if (m_ier[0] && rxq.size() > 0) return 8'h04;
        if (m_ier[1] && m_thre) return 8'h02;
        return 8'h01;
    endfunction

    function automatic logic [7:0] m_lsr();
        return {1'b0, (txq.size() == 0), (txq.size() < D), 3'b000, m_oe, (rxq.size() != 0)};
    endfunction

    task automatic m_cpu_read(input logic [2:0] off, output logic [7:0] e);
        case (off)
            3'd0: begin
                if (m_lcr[7]) e = m_dll;
                else if (rxq.size() > 0) begin e = rxq.pop_front(); m_last = e; end
                else e = m_last;
            end
            3'd1: e = m_lcr[7] ? m_dlm : {6'b0, m_ier};
            3'd2: begin e = m_iir(); if (e == 8'h02) m_thre = 0; end
            3'd3: e = m_lcr;
            3'd4: e = {3'b0, m_mcr};
            3'd5: begin e = m_lsr(); m_oe = 0; end
            3'd6: e = 8'hB0;
            default: e = m_scr;
        endcase
    endtask

    task automatic m_cpu_write(input logic [2:0] off, input logic [7:0] d);
        case (off)
            3'd0: if (m_lcr[7]) m_dll = d;
                  else begin if (txq.size() < D) txq.push_back(d); m_thre = 0; end
            3'd1: if (m_lcr[7]) m_dlm = d;
                  else begin
                      if (d[1] && !m_ier[1] && txq.size() == 0) m_thre = 1;
                      m_ier = d[1:0];
                  end
            3'd3: m_lcr = d;
            3'd4: begin
                if (d[1] && !m_mcr[1]) begin
                    rxq.delete();
                    repeat (IDN) rxq.push_back(IDB);
                    m_oe = 0;
                end
                m_mcr = d[4:0];
            end
            3'd7: m_scr = d;
            default: ;
        endcase
    endtask

    task automatic m_rv(input bit wr, input bit a0, input logic [31:0] d,
                        output bit chk, output logic [31:0] e);
        logic [7:0] b;
        chk = 0; e = 0;
        if (wr) begin
            if (!a0) begin
                if (rxq.size() < D) rxq.push_back(d[7:0]); else m_oe = 1;
            end else if (d[0]) txq.delete();
        end else if (a0) begin
            chk = 1;
            e = {15'b0, m_oe, 8'(txq.size()), 8'(rxq.size())};
        end else begin
            chk = 1;
            if (txq.size() > 0) begin
                b = txq.pop_front();
                e = {23'b0, 1'b1, b};
                if (txq.size() == 0) m_thre = 1;
            end
        end
    endtask

    task automatic cpu_rd(input logic [2:0] off);
        logic [7:0] e;
        @(posedge clk); #1;
        m_cpu_read(off, e);
        cpu_q.push_back({off, e});
        port = BASE | {9'b0, off};
        cpu_iordin = ~cpu_iordin;
        @(posedge clk); #1;
        check("iord_ack", cpu_iordout, cpu_iordin);
    endtask

    task automatic cpu_wr(input logic [2:0] off, input logic [7:0] d);
        @(posedge clk); #1;
        m_cpu_write(off, d);
        port = BASE | {9'b0, off};
        din = d;
        cpu_iowrin = ~cpu_iowrin;
        @(posedge clk); #1;
        $display("cpu wr off=%0d din=%02h", off, d);
    endtask

    task automatic rv_op(input bit wr, input bit a0, input logic [31:0] d);
        bit chk;
        logic [31:0] e;
        int n;
        @(posedge clk); #1;
        m_rv(wr, a0, d, chk, e);
        rv_q.push_back({chk, e});
        r_valid = 1; r_wr = wr; r_addr = {9'b0, a0}; r_din = d; r_lane = 4'h1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!r_ready && n < 8);
        r_valid = 0;
        checks++;
        if (!r_ready) begin
            failures++;
            $display("FAIL rv_ready_timeout actual=0 required=1");
            void'(rv_q.pop_back());
        end
    endtask

    // RISC-V RX push and CPU RBR read presented in the same cycle.
    task automatic push_and_pop(input logic [7:0] b);
        bit chk;
        logic [31:0] e;
        logic [7:0] ce;
        @(posedge clk); #1;
        m_cpu_read(3'd0, ce);
        cpu_q.push_back({3'd0, ce});
        m_rv(1'b1, 1'b0, {24'b0, b}, chk, e);
        rv_q.push_back({chk, e});
        port = BASE; cpu_iordin = ~cpu_iordin;
        r_valid = 1; r_wr = 1; r_addr = '0; r_din = {24'b0, b}; r_lane = 4'h1;
        @(posedge clk); #1;
        r_valid = 0;
        check("pushpop_ready", r_ready, 1);
    endtask

    task automatic chk_irq();
        @(posedge clk); #1;
        check("irq", irq, {31'b0, m_mcr[3] && (m_iir() != 8'h01)});
    endtask

    always @(negedge clk) begin
        if (reset_n && (cpu_iordin !== cpu_iordout)) begin
            if (cpu_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL cpu_rd_unexpected actual=%02h required=none", dout);
            end else begin
                cpu_ent = cpu_q.pop_front();
                $display("cpu rd off=%0d dout=%02h exp=%02h", cpu_ent[10:8], dout, cpu_ent[7:0]);
                check($sformatf("cpu_rd_off%0d", cpu_ent[10:8]), {24'b0, dout}, {24'b0, cpu_ent[7:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && r_ready) begin
            if (rv_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rv_unexpected_ready actual=%0h required=none", r_dout);
            end else begin
                rv_ent = rv_q.pop_front();
                $display("rv resp r_dout=%08h exp=%08h chk=%0d", r_dout, rv_ent[31:0], rv_ent[32]);
                if (rv_ent[32]) check("rv_rd", r_dout, rv_ent[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_r_ready", r_ready, 0);
        check("rst_r_dout", r_dout, 0);
        check("rst_irq", irq, 0);
        check("rst_iordout", cpu_iordout, 0);
        check("rst_iowrout", cpu_iowrout, 0);
        reset_n = 1;

        cpu_rd(5); cpu_rd(2);
        cpu_wr(3, 8'h80); cpu_rd(0); cpu_rd(1); cpu_wr(3, 8'h00);

        // RTS rising edge loads the ID burst
        cpu_wr(4, 8'h00); cpu_wr(4, 8'h0B);
        repeat (IDN) cpu_rd(0);
        cpu_rd(5); chk_irq();

        // RX data-available interrupt
        cpu_wr(1, 8'h01); cpu_wr(4, 8'h08);
        rv_op(1, 0, 32'h12); chk_irq();
        cpu_rd(2); cpu_rd(0); chk_irq();

        // Overrun on D+1 pushes
        for (int i = 0; i <= D; i++) rv_op(1, 0, $urandom & 32'hFF);
        rv_op(0, 1, 0); cpu_rd(5); cpu_rd(5);

        // Same-cycle push and pop with RX full
        push_and_pop(8'hA5);
        rv_op(0, 1, 0); cpu_rd(5); chk_irq();
        repeat (D) cpu_rd(0);

        // TX path and THRE interrupt
        cpu_wr(1, 8'h02); cpu_rd(2); chk_irq();
        cpu_wr(0, 8'h41); cpu_wr(0, 8'h42);
        rv_op(0, 0, 0); rv_op(0, 0, 0); chk_irq();
        rv_op(0, 0, 0); cpu_rd(2); chk_irq();

        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 11);
            case (op)
                0, 1, 2: rv_op(1, 0, $urandom & 32'hFF);
                3:       rv_op(0, 0, 0);
                4:       rv_op(0, 1, 0);
                5:       cpu_wr(0, 8'($urandom));
                6:       cpu_rd(0);
                7:       cpu_rd(5);
                8:       cpu_rd(2);
                9:       if ($urandom_range(0, 1) == 1) cpu_wr(1, 8'($urandom_range(0, 3)));
                         else cpu_wr(4, 8'($urandom_range(0, 31)) | 8'h08);
                10:      if ($urandom_range(0, 2) == 0) rv_op(1, 1, 32'h1);
                         else begin cpu_wr(7, 8'($urandom)); cpu_rd(7); end
                default: push_and_pop(8'($urandom));
            endcase
            chk_irq();
        end

        // Asynchronous reset in mid-cycle
        cpu_wr(7, 8'h5A);
        @(posedge clk); #3;
        reset_n = 0;
        #1;
        cpu_iordin = 0; cpu_iowrin = 0;
        check("async_rst_irq", irq, 0);
        check("async_rst_ready", r_ready, 0);
        m_reset();
        @(posedge clk); #1;
        reset_n = 1;
        cpu_rd(5); cpu_rd(7); cpu_rd(2); rv_op(0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("cpu_q_drained", cpu_q.size(), 0);
        check("rv_q_drained", rv_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
